csr_trap_ctrl: RTL and testbench

- Trap sequencer for the machine-mode CSR file.
- On ecall/ebreak, a timer interrupt or an external interrupt, it:
  - stalls the pipeline,
  - writes mepc, mcause and mstatus through the CSR file's single write port, one per cycle,
  - redirects fetch to mtvec.
- On mret it restores mstatus and redirects fetch to mepc.
- Sits beside ex; its CSR write port is muxed ahead of ex's port and wins whenever csr_wen_o=1.

---
 rtl/csr_trap_ctrl_pkg.sv | 52 +++++
 rtl/csr_trap_ctrl.sv | 266 ++++++++++++++++++++++++++
 tb/tb_csr_trap_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_trap_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// csr_trap_ctrl_pkg
// Shared definitions for the machine-mode trap sequencer:
//   - CSR addresses (mstatus, mie, mtvec, mepc, mcause)
//   - SYSTEM instruction encodings (ecall, ebreak, mret)
//   - mstatus / mie bit indices
//   - default mcause codes
//   - trap event classification type
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

package csr_trap_ctrl_pkg;

   typedef logic [11:0] csr_addr_t;

   // CSR addresses
   localparam csr_addr_t CSR_MSTATUS = 12'h300;
   localparam csr_addr_t CSR_MIE     = 12'h304;
   localparam csr_addr_t CSR_MTVEC   = 12'h305;
   localparam csr_addr_t CSR_MEPC    = 12'h341;
   localparam csr_addr_t CSR_MCAUSE  = 12'h342;

   // Instruction encodings
   localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
   localparam logic [31:0] INST_MRET   = 32'h3020_0073;

   // mstatus bit positions
   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;

   // mie bit positions
   localparam int MIE_MTIE = 7;
   localparam int MIE_MEIE = 11;

   // Default mcause codes
   localparam logic [31:0] CAUSE_ECALL_DEF  = 32'd11;
   localparam logic [31:0] CAUSE_EBREAK_DEF = 32'd3;
   localparam logic [31:0] CAUSE_TIMER_DEF  = 32'h8000_0007;
   localparam logic [31:0] CAUSE_EXT_DEF    = 32'h8000_000B;

   // What the instruction/interrupt inputs request while idle
   typedef enum logic [1:0] {
      EVT_NONE = 2'd0,
      EVT_EXC  = 2'd1,
      EVT_MRET = 2'd2,
      EVT_IRQ  = 2'd3
   } trap_evt_e;

endpackage

// File: rtl/csr_trap_ctrl.sv
// ---------------------------------------------------------------------------
// csr_trap_ctrl
// Machine-mode trap sequencer. On ecall/ebreak or an enabled interrupt it
// stalls the pipeline, writes mepc, mcause and mstatus through the CSR file's
// single write port (one per cycle) and redirects fetch to mtvec. On mret it
// restores mstatus and redirects fetch to mepc.
//
// Ports:
//   clk, rstn         clock, asynchronous active-low reset
//   inst_i            instruction in ex
//   inst_addr_i       PC of the instruction in ex
//   inst_valid_i      ex holds a real instruction
//   irq_timer_i       timer interrupt level
//   irq_ext_i         external interrupt level
//   mtvec_i, mepc_i, mstatus_i, mie_i   current CSR values
//   stall_o           hold PC/if/id/ex
//   jump_o            redirect fetch this cycle
//   jump_addr_o       redirect target
//   csr_wen_o         CSR write enable (wins over ex's write port)
//   csr_waddr_o       CSR write address, zero-extended 12-bit address
//   csr_wdata_o       CSR write data
//
// Build option:
//   CSR_TRAP_VECTOR_EN  when defined, interrupts with mtvec mode 2'b01 jump to
//                       base + 4*cause[4:0]; otherwise the base is always used.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module csr_trap_ctrl
   import csr_trap_ctrl_pkg::*;
#(
   parameter int              XLEN          = 32,
   parameter logic [XLEN-1:0] MCAUSE_ECALL  = XLEN'(CAUSE_ECALL_DEF),
   parameter logic [XLEN-1:0] MCAUSE_EBREAK = XLEN'(CAUSE_EBREAK_DEF),
   parameter logic [XLEN-1:0] MCAUSE_TIMER  = XLEN'(CAUSE_TIMER_DEF),
   parameter logic [XLEN-1:0] MCAUSE_EXT    = XLEN'(CAUSE_EXT_DEF)
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic [31:0]     inst_i,
   input  logic [XLEN-1:0] inst_addr_i,
   input  logic            inst_valid_i,
   input  logic            irq_timer_i,
   input  logic            irq_ext_i,
   input  logic [XLEN-1:0] mtvec_i,
   input  logic [XLEN-1:0] mepc_i,
   input  logic [XLEN-1:0] mstatus_i,
   input  logic [XLEN-1:0] mie_i,
   output logic            stall_o,
   output logic            jump_o,
   output logic [XLEN-1:0] jump_addr_o,
   output logic            csr_wen_o,
   output logic [XLEN-1:0] csr_waddr_o,
   output logic [XLEN-1:0] csr_wdata_o
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_W_MEPC    = 3'd1;
   localparam logic [2:0] S_W_MCAUSE  = 3'd2;
   localparam logic [2:0] S_W_MSTATUS = 3'd3;
   localparam logic [2:0] S_R_MSTATUS = 3'd4;
   localparam logic [2:0] S_JUMP      = 3'd5;

   logic [2:0]      state_r;
   logic [2:0]      state_nxt_s;
   logic [XLEN-1:0] epc_r;
   logic [XLEN-1:0] cause_r;
   logic [XLEN-1:0] target_r;

   logic            is_ecall_s;
   logic            is_ebreak_s;
   logic            is_mret_s;
   logic            irq_ext_s;
   logic            irq_tmr_s;
   logic            int_en_s;
   trap_evt_e       evt_s;
   logic [XLEN-1:0] irq_cause_s;
   logic [XLEN-1:0] trap_base_s;
   logic [XLEN-1:0] trap_target_s;

   logic            stall_s;
   logic            jump_s;
   logic [XLEN-1:0] jump_addr_s;
   logic            wen_s;
   logic [XLEN-1:0] waddr_s;
   logic [XLEN-1:0] wdata_s;
   logic            unused_ok_s;

   // mstatus on trap entry: MPIE <= MIE, MIE <= 0, MPP <= M-mode
   function automatic logic [XLEN-1:0] mstatus_on_trap(input logic [XLEN-1:0] cur);
      logic [XLEN-1:0] upd;
      upd                                = cur;
      upd[MSTATUS_MPIE]                  = cur[MSTATUS_MIE];
      upd[MSTATUS_MIE]                   = 1'b0;
      upd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      return upd;
   endfunction

   // mstatus on mret: MIE <= MPIE, MPIE <= 1 (MPP is left untouched)
   function automatic logic [XLEN-1:0] mstatus_on_mret(input logic [XLEN-1:0] cur);
      logic [XLEN-1:0] upd;
      upd               = cur;
      upd[MSTATUS_MIE]  = cur[MSTATUS_MPIE];
      upd[MSTATUS_MPIE] = 1'b1;
      return upd;
   endfunction

   // Zero-extend a 12-bit CSR address to the write-port width
   function automatic logic [XLEN-1:0] csr_addr_ext(input csr_addr_t a);
      return {{(XLEN-12){1'b0}}, a};
   endfunction

   // Bits of the CSR inputs this block does not look at
   assign unused_ok_s = ^{mie_i, mtvec_i[1:0], CSR_MIE, CSR_MTVEC};

   // Decode the ex instruction and classify the pending event by priority
   always_comb begin
      is_ecall_s  = inst_valid_i & (inst_i == INST_ECALL);
      is_ebreak_s = inst_valid_i & (inst_i == INST_EBREAK);
      is_mret_s   = inst_valid_i & (inst_i == INST_MRET);
      irq_ext_s   = irq_ext_i & mie_i[MIE_MEIE];
      irq_tmr_s   = irq_timer_i & mie_i[MIE_MTIE];
      int_en_s    = mstatus_i[MSTATUS_MIE] & (irq_ext_s | irq_tmr_s);

      // Interrupts are only taken against a real instruction so that epc
      // points at something that will be re-executed after return.
      if (is_ecall_s | is_ebreak_s) begin
         evt_s = EVT_EXC;
      end else if (is_mret_s) begin
         evt_s = EVT_MRET;
      end else if (int_en_s & inst_valid_i) begin
         evt_s = EVT_IRQ;
      end else begin
         evt_s = EVT_NONE;
      end

      if (irq_ext_s) begin
         irq_cause_s = MCAUSE_EXT;
      end else begin
         irq_cause_s = MCAUSE_TIMER;
      end
   end

   // Trap vector target from mtvec and the latched cause
   always_comb begin
      trap_base_s = {mtvec_i[XLEN-1:2], 2'b00};
`ifdef CSR_TRAP_VECTOR_EN
      if (cause_r[XLEN-1] && (mtvec_i[1:0] == 2'b01)) begin
         trap_target_s = trap_base_s + {{(XLEN-7){1'b0}}, cause_r[4:0], 2'b00};
      end else begin
         trap_target_s = trap_base_s;
      end
`else
      trap_target_s = trap_base_s;
`endif
   end

   // Next-state logic of the trap sequencer
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_IDLE: begin
            case (evt_s)
               EVT_EXC:  state_nxt_s = S_W_MEPC;
               EVT_IRQ:  state_nxt_s = S_W_MEPC;
               EVT_MRET: state_nxt_s = S_R_MSTATUS;
               default:  state_nxt_s = S_IDLE;
            endcase
         end
         S_W_MEPC:    state_nxt_s = S_W_MCAUSE;
         S_W_MCAUSE:  state_nxt_s = S_W_MSTATUS;
         S_W_MSTATUS: state_nxt_s = S_JUMP;
         S_R_MSTATUS: state_nxt_s = S_JUMP;
         S_JUMP:      state_nxt_s = S_IDLE;
         default:     state_nxt_s = S_IDLE;
      endcase
   end

   // State, latched epc/cause and redirect target
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r  <= S_IDLE;
         epc_r    <= {XLEN{1'b0}};
         cause_r  <= {XLEN{1'b0}};
         target_r <= {XLEN{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         case (state_r)
            S_IDLE: begin
               if (evt_s == EVT_EXC) begin
                  epc_r   <= inst_addr_i;
                  cause_r <= is_ecall_s ? MCAUSE_ECALL : MCAUSE_EBREAK;
               end else if (evt_s == EVT_IRQ) begin
                  epc_r   <= inst_addr_i;
                  cause_r <= irq_cause_s;
               end
            end
            S_W_MSTATUS: target_r <= trap_target_s;
            S_R_MSTATUS: target_r <= mepc_i;
            default: begin
               target_r <= target_r;
            end
         endcase
      end
   end

   // Output decode; idle stall is raised combinationally on detection
   always_comb begin
      stall_s     = 1'b0;
      jump_s      = 1'b0;
      jump_addr_s = {XLEN{1'b0}};
      wen_s       = 1'b0;
      waddr_s     = {XLEN{1'b0}};
      wdata_s     = {XLEN{1'b0}};
      case (state_r)
         S_IDLE: begin
            // Gated with rstn so all outputs read 0 while reset is held
            if (rstn && (evt_s != EVT_NONE)) begin
               stall_s = 1'b1;
            end else begin
               stall_s = 1'b0;
            end
         end
         S_W_MEPC: begin
            stall_s = 1'b1;
            wen_s   = 1'b1;
            waddr_s = csr_addr_ext(CSR_MEPC);
            wdata_s = epc_r;
         end
         S_W_MCAUSE: begin
            stall_s = 1'b1;
            wen_s   = 1'b1;
            waddr_s = csr_addr_ext(CSR_MCAUSE);
            wdata_s = cause_r;
         end
         S_W_MSTATUS: begin
            stall_s = 1'b1;
            wen_s   = 1'b1;
            waddr_s = csr_addr_ext(CSR_MSTATUS);
            wdata_s = mstatus_on_trap(mstatus_i);
         end
         S_R_MSTATUS: begin
            stall_s = 1'b1;
            wen_s   = 1'b1;
            waddr_s = csr_addr_ext(CSR_MSTATUS);
            wdata_s = mstatus_on_mret(mstatus_i);
         end
         S_JUMP: begin
            stall_s     = 1'b1;
            jump_s      = 1'b1;
            jump_addr_s = target_r;
         end
         default: begin
            stall_s = 1'b0;
         end
      endcase
   end

   assign stall_o     = stall_s;
   assign jump_o      = jump_s;
   assign jump_addr_o = jump_addr_s;
   assign csr_wen_o   = wen_s;
   assign csr_waddr_o = waddr_s;
   assign csr_wdata_o = wdata_s;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// ---------------------------------------------------------------------------
// tb_csr_trap_ctrl
// Self-checking bench for csr_trap_ctrl: directed scenarios with literal
// expectations followed by randomized traffic checked against a
// transaction-level model that keeps its own copy of the CSR file.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_csr_trap_ctrl;

   localparam logic [31:0] ECALL  = 32'h0000_0073;
   localparam logic [31:0] EBREAK = 32'h0010_0073;
   localparam logic [31:0] MRET   = 32'h3020_0073;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rstn;
   logic [31:0] inst;
   logic [31:0] inst_addr;
   logic        inst_valid;
   logic        irq_timer;
   logic        irq_ext;
   logic [31:0] mtvec;
   logic [31:0] mepc;
   logic [31:0] mstatus;
   logic [31:0] mie;
   logic        stall;
   logic        jump;
   logic [31:0] jump_addr;
   logic        csr_wen;
   logic [31:0] csr_waddr;
   logic [31:0] csr_wdata;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic        st;
      logic        we;
      logic [31:0] wa;
      logic [31:0] wd;
      logic        jp;
      logic [31:0] ja;
   } beat_t;

   beat_t       exp_q[$];
   logic [31:0] pend_mstatus;
   logic [31:0] pend_mepc;
   bit          pend_valid;

   csr_trap_ctrl dut (
      .clk          (clk),
      .rstn         (rstn),
      .inst_i       (inst),
      .inst_addr_i  (inst_addr),
      .inst_valid_i (inst_valid),
      .irq_timer_i  (irq_timer),
      .irq_ext_i    (irq_ext),
      .mtvec_i      (mtvec),
      .mepc_i       (mepc),
      .mstatus_i    (mstatus),
      .mie_i        (mie),
      .stall_o      (stall),
      .jump_o       (jump),
      .jump_addr_o  (jump_addr),
      .csr_wen_o    (csr_wen),
      .csr_waddr_o  (csr_waddr),
      .csr_wdata_o  (csr_wdata)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] i, input logic [31:0] pc, input logic v);
      inst       = i;
      inst_addr  = pc;
      inst_valid = v;
   endtask

   task automatic check_outputs(input string tag, input beat_t b);
      check_val({tag, ".stall"}, {31'd0, stall},   {31'd0, b.st});
      check_val({tag, ".wen"},   {31'd0, csr_wen}, {31'd0, b.we});
      check_val({tag, ".waddr"}, csr_waddr,        b.wa);
      check_val({tag, ".wdata"}, csr_wdata,        b.wd);
      check_val({tag, ".jump"},  {31'd0, jump},    {31'd0, b.jp});
      check_val({tag, ".jaddr"}, jump_addr,        b.ja);
   endtask

   function automatic beat_t mk(input logic st, input logic we, input logic [31:0] wa,
                                input logic [31:0] wd, input logic jp, input logic [31:0] ja);
      beat_t b;
      b.st = st; b.we = we; b.wa = wa; b.wd = wd; b.jp = jp; b.ja = ja;
      return b;
   endfunction

   task automatic expect_beat(input string tag, input logic st, input logic we,
                              input logic [31:0] wa, input logic [31:0] wd,
                              input logic jp, input logic [31:0] ja);
      @(negedge clk);
      check_outputs(tag, mk(st, we, wa, wd, jp, ja));
   endtask

   // Reference model: decides what the whole sequence looks like from the
   // inputs of an idle cycle and queues one expected beat per cycle.
   task automatic model_idle();
      bit          exc;
      bit          ret;
      bit          ext_on;
      bit          irq_pend;
      logic [31:0] cause;
      logic [31:0] tgt;
      logic [31:0] ms_new;
      exc      = inst_valid && (inst == ECALL || inst == EBREAK);
      ret      = inst_valid && (inst == MRET);
      ext_on   = irq_ext && mie[11];
      irq_pend = inst_valid && mstatus[3] && (ext_on || (irq_timer && mie[7]));
      if (exc || (!ret && irq_pend)) begin
         if (exc) cause = (inst == ECALL) ? 32'd11 : 32'd3;
         else     cause = ext_on ? 32'h8000_000B : 32'h8000_0007;
         tgt = mtvec & 32'hFFFF_FFFC;
`ifdef CSR_TRAP_VECTOR_EN
         if (!exc && mtvec[1:0] == 2'b01) tgt = tgt + 32'd4 * (cause & 32'h1F);
`endif
         ms_new = (mstatus & ~32'h0000_1888) | 32'h0000_1800 | (mstatus[3] ? 32'h80 : 32'h0);
         exp_q.push_back(mk(1'b1, 1'b0, 32'h0,   32'h0,     1'b0, 32'h0));
         exp_q.push_back(mk(1'b1, 1'b1, 32'h341, inst_addr, 1'b0, 32'h0));
         exp_q.push_back(mk(1'b1, 1'b1, 32'h342, cause,     1'b0, 32'h0));
         exp_q.push_back(mk(1'b1, 1'b1, 32'h300, ms_new,    1'b0, 32'h0));
         exp_q.push_back(mk(1'b1, 1'b0, 32'h0,   32'h0,     1'b1, tgt));
         pend_mstatus = ms_new;
         pend_mepc    = inst_addr;
         pend_valid   = 1'b1;
      end else if (ret) begin
         ms_new = (mstatus & ~32'h0000_0088) | 32'h80 | (mstatus[7] ? 32'h8 : 32'h0);
         exp_q.push_back(mk(1'b1, 1'b0, 32'h0,   32'h0,  1'b0, 32'h0));
         exp_q.push_back(mk(1'b1, 1'b1, 32'h300, ms_new, 1'b0, 32'h0));
         exp_q.push_back(mk(1'b1, 1'b0, 32'h0,   32'h0,  1'b1, mepc));
         pend_mstatus = ms_new;
         pend_mepc    = mepc;
         pend_valid   = 1'b1;
      end else begin
         exp_q.push_back(mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] vec_exp;
      beat_t       b;
      int          sel;

      // Reset: outputs must stay low even with an ecall presented
      rstn = 1'b0; irq_timer = 1'b0; irq_ext = 1'b0;
      mtvec = 32'h200; mepc = 32'h0; mstatus = 32'h8; mie = 32'h0;
      drive(ECALL, 32'h100, 1'b1);
      pend_valid = 1'b0; pend_mstatus = 32'h0; pend_mepc = 32'h0;
      expect_beat("reset", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      next_cycle();
      drive(NOP, 32'h0, 1'b0);
      rstn = 1'b1;
      expect_beat("post_reset", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

      // ecall at 0x100
      next_cycle();
      drive(ECALL, 32'h100, 1'b1);
      expect_beat("ecall.det", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      next_cycle(); drive(NOP, 32'h0, 1'b0);
      expect_beat("ecall.mepc",    1'b1, 1'b1, 32'h341, 32'h100,  1'b0, 32'h0);
      next_cycle(); expect_beat("ecall.mcause",  1'b1, 1'b1, 32'h342, 32'd11,   1'b0, 32'h0);
      next_cycle(); expect_beat("ecall.mstatus", 1'b1, 1'b1, 32'h300, 32'h1880, 1'b0, 32'h0);
      next_cycle(); expect_beat("ecall.jump",    1'b1, 1'b0, 32'h0,   32'h0,    1'b1, 32'h200);
      next_cycle(); expect_beat("ecall.done",    1'b0, 1'b0, 32'h0,   32'h0,    1'b0, 32'h0);

      // mret back to 0x104
      next_cycle();
      mstatus = 32'h1880; mepc = 32'h104;
      drive(MRET, 32'h280, 1'b1);
      expect_beat("mret.det", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      next_cycle(); drive(NOP, 32'h0, 1'b0);
      expect_beat("mret.mstatus", 1'b1, 1'b1, 32'h300, 32'h1888, 1'b0, 32'h0);
      next_cycle(); expect_beat("mret.jump", 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h104);
      next_cycle(); expect_beat("mret.done", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

      // External interrupt wins over timer
      next_cycle();
      mstatus = 32'h8; mie = 32'h880; irq_ext = 1'b1; irq_timer = 1'b1;
      drive(NOP, 32'h300, 1'b1);
      expect_beat("ext.det", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      next_cycle(); expect_beat("ext.mepc",    1'b1, 1'b1, 32'h341, 32'h300,       1'b0, 32'h0);
      next_cycle(); expect_beat("ext.mcause",  1'b1, 1'b1, 32'h342, 32'h8000_000B, 1'b0, 32'h0);
      next_cycle(); expect_beat("ext.mstatus", 1'b1, 1'b1, 32'h300, 32'h1880,      1'b0, 32'h0);
      next_cycle(); expect_beat("ext.jump",    1'b1, 1'b0, 32'h0,   32'h0,         1'b1, 32'h200);
      next_cycle();
      mstatus = 32'h1880;
      expect_beat("ext.masked_after", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

      // Masking: MIE=0, then a bubble
      next_cycle();
      irq_ext = 1'b0; irq_timer = 1'b1; mstatus = 32'h0; mie = 32'h80;
      drive(NOP, 32'h500, 1'b1);
      expect_beat("mask.mie0", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      next_cycle();
      mstatus = 32'h8;
      drive(NOP, 32'h500, 1'b0);
      expect_beat("mask.bubble", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

      // ecall and external interrupt together
      next_cycle();
      irq_timer = 1'b0; irq_ext = 1'b1; mie = 32'h800; mstatus = 32'h8;
      drive(ECALL, 32'h400, 1'b1);
      expect_beat("ecall_irq.det", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      next_cycle(); drive(NOP, 32'h404, 1'b1);
      expect_beat("ecall_irq.mepc",   1'b1, 1'b1, 32'h341, 32'h400,  1'b0, 32'h0);
      next_cycle(); expect_beat("ecall_irq.mcause",  1'b1, 1'b1, 32'h342, 32'd11,   1'b0, 32'h0);
      next_cycle(); expect_beat("ecall_irq.mstatus", 1'b1, 1'b1, 32'h300, 32'h1880, 1'b0, 32'h0);
      next_cycle(); expect_beat("ecall_irq.jump",    1'b1, 1'b0, 32'h0,   32'h0,    1'b1, 32'h200);
      next_cycle();
      mstatus = 32'h1880;
      expect_beat("ecall_irq.masked", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

      // Reset pulse in W_MCAUSE
      next_cycle();
      irq_ext = 1'b0; mie = 32'h0; mstatus = 32'h8;
      drive(ECALL, 32'h600, 1'b1);
      expect_beat("rst.det", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      next_cycle(); drive(NOP, 32'h0, 1'b0);
      expect_beat("rst.mepc", 1'b1, 1'b1, 32'h341, 32'h600, 1'b0, 32'h0);
      next_cycle();
      check_val("rst.pre_wen", {31'd0, csr_wen}, 32'd1);
      rstn = 1'b0;
      #1;
      check_val("rst.async_wen",   {31'd0, csr_wen}, 32'd0);
      check_val("rst.async_stall", {31'd0, stall},   32'd0);
      check_val("rst.async_waddr", csr_waddr,        32'h0);
      check_val("rst.async_wdata", csr_wdata,        32'h0);
      @(negedge clk);
      next_cycle();
      rstn = 1'b1;
      for (int k = 0; k < 4; k++) begin
         expect_beat("rst.after", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
         next_cycle();
      end

      // Vectored mtvec with a timer interrupt, then an ebreak on the same mtvec
`ifdef CSR_TRAP_VECTOR_EN
      vec_exp = 32'h21C;
`else
      vec_exp = 32'h200;
`endif
      mtvec = 32'h201; mstatus = 32'h8; mie = 32'h80; irq_timer = 1'b1;
      drive(NOP, 32'h700, 1'b1);
      expect_beat("vec.det", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      next_cycle(); irq_timer = 1'b0;
      expect_beat("vec.mepc",    1'b1, 1'b1, 32'h341, 32'h700,       1'b0, 32'h0);
      next_cycle(); expect_beat("vec.mcause",  1'b1, 1'b1, 32'h342, 32'h8000_0007, 1'b0, 32'h0);
      next_cycle(); expect_beat("vec.mstatus", 1'b1, 1'b1, 32'h300, 32'h1880,      1'b0, 32'h0);
      next_cycle(); expect_beat("vec.jump",    1'b1, 1'b0, 32'h0,   32'h0,         1'b1, vec_exp);
      next_cycle();
      mstatus = 32'h8;
      drive(EBREAK, 32'h704, 1'b1);
      expect_beat("ebrk.det", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      next_cycle(); drive(NOP, 32'h0, 1'b0);
      expect_beat("ebrk.mepc",    1'b1, 1'b1, 32'h341, 32'h704,  1'b0, 32'h0);
      next_cycle(); expect_beat("ebrk.mcause",  1'b1, 1'b1, 32'h342, 32'd3,    1'b0, 32'h0);
      next_cycle(); expect_beat("ebrk.mstatus", 1'b1, 1'b1, 32'h300, 32'h1880, 1'b0, 32'h0);
      next_cycle(); expect_beat("ebrk.jump",    1'b1, 1'b0, 32'h0,   32'h0,    1'b1, 32'h200);
      @(negedge clk);

      // Randomized traffic against the model
      exp_q.delete();
      pend_valid = 1'b0;
      mstatus = 32'h8; mie = 32'h880; mtvec = 32'h1000; mepc = 32'h0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         next_cycle();
         if (exp_q.size() == 0) begin
            if (pend_valid) begin
               mstatus    = pend_mstatus;
               mepc       = pend_mepc;
               pend_valid = 1'b0;
            end
            if ($urandom_range(0, 7) == 0) begin
               mstatus = $urandom;
               mie     = $urandom;
               mtvec   = $urandom;
               mepc    = $urandom & 32'hFFFF_FFFC;
            end
         end
         sel = $urandom_range(0, 9);
         case (sel)
            0:       inst = ECALL;
            1:       inst = EBREAK;
            2, 3:    inst = MRET;
            default: inst = $urandom;
         endcase
         inst_valid = ($urandom_range(0, 3) != 0);
         inst_addr  = $urandom & 32'hFFFF_FFFC;
         irq_timer  = $urandom_range(0, 1) == 1;
         irq_ext    = $urandom_range(0, 1) == 1;
         if (exp_q.size() == 0) model_idle();
         @(negedge clk);
         b = exp_q.pop_front();
         check_outputs("rand", b);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
